// File: rtl/flt_regmc_pkg.sv
// Shared register map, field positions and address decode for the
// multi-channel filter register controller.
package flt_regmc_pkg;

  localparam int unsigned NCH_MAX = 4;

  localparam logic [11:0] GLB_BASE    = 12'h000;
  localparam logic [11:0] GCTRL_OFS   = 12'h000;
  localparam logic [11:0] GSTAT_OFS   = 12'h004;
  localparam logic [11:0] INTEN_OFS   = 12'h008;
  localparam logic [11:0] INTSTAT_OFS = 12'h00C;

  localparam logic [11:0] CH_BASE   = 12'h100;
  localparam logic [11:0] CH_STRIDE = 12'h010;
  localparam logic [3:0]  CCTRL_OFS = 4'h0;
  localparam logic [3:0]  SRC_OFS   = 4'h4;
  localparam logic [3:0]  FRM_OFS   = 4'h8;
  localparam logic [3:0]  COLOR_OFS = 4'hC;

  localparam int unsigned GCTRL_SRST_BIT  = 1;
  localparam int unsigned GSTAT_PEND_LSB  = 8;
  localparam int unsigned CCTRL_START_BIT = 0;
  localparam int unsigned CCTRL_PEND_BIT  = 8;
  localparam int unsigned CCTRL_BUSY_BIT  = 0;

  typedef enum logic [1:0] {
    G_GCTRL   = GCTRL_OFS[3:2],
    G_GSTAT   = GSTAT_OFS[3:2],
    G_INTEN   = INTEN_OFS[3:2],
    G_INTSTAT = INTSTAT_OFS[3:2]
  } glb_reg_e;

  typedef enum logic [1:0] {
    REG_CCTRL = CCTRL_OFS[3:2],
    REG_SRC   = SRC_OFS[3:2],
    REG_FRM   = FRM_OFS[3:2],
    REG_COLOR = COLOR_OFS[3:2]
  } ch_reg_e;

  typedef struct packed {
    logic     glb;
    logic     ch;
    logic [1:0] idx;
    glb_reg_e greg;
    ch_reg_e  creg;
  } dec_t;

  // Word-granular decode; the channel index assumes a 0x10 stride.
  function automatic dec_t addr_dec(input logic [11:0] addr, input int unsigned nch);
    dec_t        d;
    logic [11:0] a;
    logic [11:0] rel;
    a      = {addr[11:2], 2'b00};
    rel    = a - CH_BASE;
    d      = '0;
    d.glb  = (a[11:4] == GLB_BASE[11:4]);
    d.ch   = (a >= CH_BASE) && (rel < 12'(nch * CH_STRIDE));
    d.idx  = rel[5:4];
    d.greg = glb_reg_e'(a[3:2]);
    d.creg = ch_reg_e'(rel[3:2]);
    return d;
  endfunction

endpackage

// File: rtl/flt_regctrl_mc_if.sv
// Register bus between the host and the filter register controller.
interface flt_regctrl_mc_if;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;

  modport master (output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN, input RDATA);
  modport slave  (input WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN, output RDATA);
endinterface

// File: rtl/flt_regch.sv
// One filter channel: staging registers, committed copies, start queue
// of depth one and the start pulse.
module flt_regch
  import flt_regmc_pkg::*;
#(
  parameter int unsigned COLOR_W = 3
) (
  input  logic               CLK,
  input  logic               ARST,
  input  logic               wr_en,
  input  ch_reg_e            wr_reg,
  input  logic [3:0]         byteen,
  input  logic [31:0]        wdata,
  input  logic               busy,
  input  logic               srst,
  output logic               start,
  output logic               pending,
  output logic [31:0]        src_stg,
  output logic [31:0]        frm_stg,
  output logic [COLOR_W-1:0] color_stg,
  output logic [31:0]        src,
  output logic [31:0]        frm,
  output logic [COLOR_W-1:0] color
);

  logic req;
  logic launch;

  // A start still in flight counts as busy so two pulses never abut.
  always_comb begin
    req    = wr_en && (wr_reg == REG_CCTRL) && byteen[0] && wdata[CCTRL_START_BIT];
    launch = !srst && !busy && !start && (pending || req);
  end

  always_ff @(posedge CLK) begin
    if (ARST) begin
      start     <= 1'b0;
      pending   <= 1'b0;
      src_stg   <= '0;
      frm_stg   <= '0;
      color_stg <= '0;
      src       <= '0;
      frm       <= '0;
      color     <= '0;
    end else begin
      start <= 1'b0;
      if (wr_en) begin
        case (wr_reg)
          REG_SRC:
            for (int unsigned b = 0; b < 4; b++)
              if (byteen[b]) src_stg[8*b +: 8] <= wdata[8*b +: 8];
          REG_FRM:
            for (int unsigned b = 0; b < 4; b++)
              if (byteen[b]) frm_stg[8*b +: 8] <= wdata[8*b +: 8];
          REG_COLOR:
            if (byteen[0]) color_stg <= wdata[COLOR_W-1:0];
          default: ;
        endcase
      end
      if (srst) begin
        pending <= 1'b0;
      end else if (launch) begin
        src     <= src_stg;
        frm     <= frm_stg;
        color   <= color_stg;
        start   <= 1'b1;
        pending <= 1'b0;
      end else if (req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/flt_regctrl_mc.sv
// Filter register controller: bus decode, global control/interrupt bank,
// soft-reset sequencer and read mux around NCH channel banks.
module flt_regctrl_mc
  import flt_regmc_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned RST_CYC = 4,
  parameter logic [3:0]  BASE    = 4'h4
) (
  input  logic                     CLK,
  input  logic                     ARST,
  flt_regctrl_mc_if.slave          bus,
  input  logic [NCH-1:0]           FLTVC_INT,
  input  logic [NCH-1:0]           FLTVC_BUSY,
  output logic                     FLTRG_IRQ,
  output logic                     FLTRG_RSTS,
  output logic [NCH-1:0]           FLTRG_START,
  output logic [32*NCH-1:0]        FLTRG_VRAMSRC,
  output logic [32*NCH-1:0]        FLTRG_VRAMFRM,
  output logic [COLOR_W*NCH-1:0]   FLTRG_COLOR
);

  dec_t wd;
  dec_t rd;
  logic wr_sel;
  logic rd_sel;
  logic wr_glb;
  logic srst_req;
  logic [NCH-1:0] w1c;

  logic [NCH-1:0] inten;
  logic [NCH-1:0] intstat;
  logic [NCH-1:0] pend;
  logic [3:0]     srst_cnt;
  logic [31:0]    rdata;

  logic [31:0]        src_stg   [NCH];
  logic [31:0]        frm_stg   [NCH];
  logic [COLOR_W-1:0] color_stg [NCH];

  always_comb begin
    wd       = addr_dec(bus.WRADDR[11:0], NCH);
    rd       = addr_dec(bus.RDADDR[11:0], NCH);
    wr_sel   = bus.WREN && (bus.WRADDR[15:12] == BASE);
    rd_sel   = (bus.RDADDR[15:12] == BASE);
    wr_glb   = wr_sel && wd.glb && bus.BYTEEN[0];
    srst_req = wr_glb && (wd.greg == G_GCTRL) && bus.WDATA[GCTRL_SRST_BIT];
    w1c      = (wr_glb && (wd.greg == G_INTSTAT)) ? bus.WDATA[NCH-1:0] : '0;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic wr_this;
    assign wr_this = wr_sel && wd.ch && (wd.idx == 2'(c));

    flt_regch #(.COLOR_W(COLOR_W)) u_ch (
      .CLK       (CLK),
      .ARST      (ARST),
      .wr_en     (wr_this),
      .wr_reg    (wd.creg),
      .byteen    (bus.BYTEEN),
      .wdata     (bus.WDATA),
      .busy      (FLTVC_BUSY[c]),
      .srst      (FLTRG_RSTS),
      .start     (FLTRG_START[c]),
      .pending   (pend[c]),
      .src_stg   (src_stg[c]),
      .frm_stg   (frm_stg[c]),
      .color_stg (color_stg[c]),
      .src       (FLTRG_VRAMSRC[32*c +: 32]),
      .frm       (FLTRG_VRAMFRM[32*c +: 32]),
      .color     (FLTRG_COLOR[COLOR_W*c +: COLOR_W])
    );
  end

  // Set beats W1C on the same edge; soft reset wipes status for its duration.
  always_ff @(posedge CLK) begin
    if (ARST) begin
      inten      <= '0;
      intstat    <= '0;
      FLTRG_IRQ  <= 1'b0;
      FLTRG_RSTS <= 1'b0;
      srst_cnt   <= '0;
    end else begin
      if (wr_glb && (wd.greg == G_INTEN)) inten <= bus.WDATA[NCH-1:0];
      if (FLTRG_RSTS) intstat <= '0;
      else            intstat <= (intstat & ~w1c) | FLTVC_INT;
      FLTRG_IRQ <= |(intstat & inten);
      if (srst_req) begin
        srst_cnt   <= 4'(RST_CYC);
        FLTRG_RSTS <= 1'b1;
      end else if (srst_cnt != '0) begin
        srst_cnt   <= srst_cnt - 4'd1;
        FLTRG_RSTS <= (srst_cnt > 4'd1);
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_sel && rd.glb) begin
      case (rd.greg)
        G_GSTAT: begin
          rdata[NCH-1:0]                = FLTVC_BUSY;
          rdata[GSTAT_PEND_LSB +: NCH]  = pend;
        end
        G_INTEN:   rdata[NCH-1:0] = inten;
        G_INTSTAT: rdata[NCH-1:0] = intstat;
        default:   rdata = '0;
      endcase
    end else if (rd_sel && rd.ch) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (rd.idx == 2'(c)) begin
          case (rd.creg)
            REG_CCTRL: begin
              rdata[CCTRL_PEND_BIT] = pend[c];
              rdata[CCTRL_BUSY_BIT] = FLTVC_BUSY[c];
            end
            REG_SRC:   rdata = src_stg[c];
            REG_FRM:   rdata = frm_stg[c];
            REG_COLOR: rdata[COLOR_W-1:0] = color_stg[c];
            default:   rdata = '0;
          endcase
        end
      end
    end
  end

  assign bus.RDATA = rdata;

endmodule

// File: tb/tb_flt_regctrl_mc.sv
// Directed self-checking bench for flt_regctrl_mc (NCH=2, RST_CYC=4).
module tb_flt_regctrl_mc;

  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 3;

  logic           CLK = 1'b0;
  logic           ARST;
  logic [NCH-1:0] FLTVC_INT;
  logic [NCH-1:0] FLTVC_BUSY;
  logic           FLTRG_IRQ;
  logic           FLTRG_RSTS;
  logic [NCH-1:0] FLTRG_START;
  logic [32*NCH-1:0] FLTRG_VRAMSRC;
  logic [32*NCH-1:0] FLTRG_VRAMFRM;
  logic [CW*NCH-1:0] FLTRG_COLOR;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  flt_regctrl_mc_if bus();

  flt_regctrl_mc #(.NCH(NCH), .COLOR_W(CW), .RST_CYC(4), .BASE(4'h4)) dut (
    .CLK           (CLK),
    .ARST          (ARST),
    .bus           (bus),
    .FLTVC_INT     (FLTVC_INT),
    .FLTVC_BUSY    (FLTVC_BUSY),
    .FLTRG_IRQ     (FLTRG_IRQ),
    .FLTRG_RSTS    (FLTRG_RSTS),
    .FLTRG_START   (FLTRG_START),
    .FLTRG_VRAMSRC (FLTRG_VRAMSRC),
    .FLTRG_VRAMFRM (FLTRG_VRAMFRM),
    .FLTRG_COLOR   (FLTRG_COLOR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns in the cycle following the write edge.
  task automatic wr(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge CLK);
    bus.WRADDR = addr; bus.WDATA = data; bus.BYTEEN = be; bus.WREN = 1'b1;
    @(negedge CLK);
    bus.WREN = 1'b0; bus.BYTEEN = '0; bus.WDATA = '0;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [31:0] data);
    bus.RDADDR = addr; bus.RDEN = 1'b1;
    #1;
    data = bus.RDATA;
    bus.RDEN = 1'b0;
  endtask

  logic [31:0] r;
  logic [15:0] map_addr [12];
  int unsigned cnt_rsts, cnt_start, cnt_s1;

  initial begin
    map_addr = '{16'h4000, 16'h4004, 16'h4008, 16'h400C,
                 16'h4100, 16'h4104, 16'h4108, 16'h410C,
                 16'h4110, 16'h4114, 16'h4118, 16'h411C};
    ARST = 1'b1; FLTVC_INT = '0; FLTVC_BUSY = '0;
    bus.WRADDR = '0; bus.WDATA = '0; bus.BYTEEN = '0; bus.WREN = 1'b0;
    bus.RDADDR = '0; bus.RDEN = 1'b0;
    repeat (2) @(negedge CLK);
    ARST = 1'b0;

    // Reset state
    check("rst_irq",   FLTRG_IRQ,     1'b0);
    check("rst_rsts",  FLTRG_RSTS,    1'b0);
    check("rst_start", FLTRG_START,   2'b00);
    check("rst_src",   FLTRG_VRAMSRC, 64'h0);
    check("rst_frm",   FLTRG_VRAMFRM, 64'h0);
    check("rst_color", FLTRG_COLOR,   6'h0);
    for (int i = 0; i < 12; i++) begin
      rd(map_addr[i], r);
      check($sformatf("rst_rd_%h", map_addr[i]), r, 32'h0);
    end

    // Idle start on ch0
    wr(16'h4104, 32'h1000_0000, 4'hF);
    wr(16'h4108, 32'h2000_0000, 4'hF);
    wr(16'h410C, 32'h0000_0005, 4'hF);
    check("stg_not_committed", FLTRG_VRAMSRC[31:0], 32'h0);
    rd(16'h410C, r);
    check("stg_color_rd", r, 32'h5);
    wr(16'h4100, 32'h1, 4'hF);
    check("idle_start",  FLTRG_START, 2'b01);
    check("idle_src0",   FLTRG_VRAMSRC[31:0], 32'h1000_0000);
    check("idle_frm0",   FLTRG_VRAMFRM[31:0], 32'h2000_0000);
    check("idle_color0", FLTRG_COLOR[2:0], 3'd5);
    check("idle_src1",   FLTRG_VRAMSRC[63:32], 32'h0);
    @(negedge CLK);
    check("idle_start_1cyc", FLTRG_START, 2'b00);

    // Busy start on ch1: queued, second request dropped, launch uses latest staging
    FLTVC_BUSY = 2'b10;
    wr(16'h4114, 32'hA0, 4'hF);
    wr(16'h4110, 32'h1, 4'hF);
    check("busy_no_start", FLTRG_START, 2'b00);
    wr(16'h4114, 32'hB0, 4'hF);
    wr(16'h4110, 32'h1, 4'hF);
    rd(16'h4004, r);
    check("busy_gstat", r, 32'h0000_0202);
    rd(16'h4110, r);
    check("busy_cctrl1", r, 32'h0000_0101);
    check("busy_src1_held", FLTRG_VRAMSRC[63:32], 32'h0);
    @(negedge CLK);
    FLTVC_BUSY = 2'b00;
    @(negedge CLK);
    check("pend_start", FLTRG_START, 2'b10);
    check("pend_src1",  FLTRG_VRAMSRC[63:32], 32'hB0);
    cnt_s1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (FLTRG_START[1]) cnt_s1++;
    end
    check("pend_single_pulse", 32'(cnt_s1), 32'd0);
    rd(16'h4004, r);
    check("pend_gstat_clr", r, 32'h0);

    // Interrupts
    wr(16'h4008, 32'h1, 4'hF);
    @(negedge CLK); FLTVC_INT = 2'b10;
    @(negedge CLK); FLTVC_INT = 2'b00;
    @(negedge CLK);
    check("irq_masked", FLTRG_IRQ, 1'b0);
    rd(16'h400C, r);
    check("intstat_b1", r, 32'h2);
    @(negedge CLK); FLTVC_INT = 2'b01;
    @(negedge CLK); FLTVC_INT = 2'b00;
    check("irq_latency", FLTRG_IRQ, 1'b0);
    @(negedge CLK);
    check("irq_set", FLTRG_IRQ, 1'b1);
    @(negedge CLK);
    bus.WRADDR = 16'h400C; bus.WDATA = 32'h1; bus.BYTEEN = 4'hF; bus.WREN = 1'b1;
    FLTVC_INT = 2'b01;
    @(negedge CLK);
    bus.WREN = 1'b0; FLTVC_INT = 2'b00;
    rd(16'h400C, r);
    check("set_beats_w1c", r, 32'h3);
    wr(16'h400C, 32'h1, 4'hF);
    rd(16'h400C, r);
    check("w1c_b0", r, 32'h2);
    check("irq_hold_1cyc", FLTRG_IRQ, 1'b1);
    @(negedge CLK);
    check("irq_clr", FLTRG_IRQ, 1'b0);

    // Soft reset with ch0 pending and INTSTAT[1] still set
    FLTVC_BUSY = 2'b01;
    wr(16'h4100, 32'h1, 4'hF);
    wr(16'h4104, 32'h3333, 4'hF);
    rd(16'h4004, r);
    check("srst_pre_gstat", r, 32'h0000_0101);
    wr(16'h4000, 32'h2, 4'hF);
    FLTVC_BUSY = 2'b00;
    cnt_rsts = 0; cnt_start = 0;
    for (int i = 0; i < 7; i++) begin
      if (FLTRG_RSTS) cnt_rsts++;
      if (FLTRG_START != '0) cnt_start++;
      if (i == 0) check("srst_first", FLTRG_RSTS, 1'b1);
      if (i == 4) check("srst_off", FLTRG_RSTS, 1'b0);
      if (i == 1) begin
        bus.WRADDR = 16'h4110; bus.WDATA = 32'h1; bus.BYTEEN = 4'hF; bus.WREN = 1'b1;
      end else begin
        bus.WREN = 1'b0;
      end
      @(negedge CLK);
    end
    check("srst_len",      32'(cnt_rsts),  32'd4);
    check("srst_no_start", 32'(cnt_start), 32'd0);
    rd(16'h4004, r);
    check("srst_gstat", r, 32'h0);
    rd(16'h400C, r);
    check("srst_intstat", r, 32'h0);
    rd(16'h4008, r);
    check("srst_inten", r, 32'h1);
    rd(16'h4104, r);
    check("srst_stg_kept", r, 32'h3333);
    check("srst_src_kept", FLTRG_VRAMSRC, {32'hB0, 32'h1000_0000});
    check("srst_color_kept", FLTRG_COLOR, {3'd0, 3'd5});

    // Byte enables, channel isolation, foreign base
    wr(16'h4104, 32'h0, 4'hF);
    wr(16'h4104, 32'hFFAB_FFFF, 4'h4);
    rd(16'h4104, r);
    check("be_src0", r, 32'h00AB_0000);
    rd(16'h4114, r);
    check("be_src1_untouched", r, 32'hB0);
    wr(16'h410C, 32'h7, 4'h2);
    rd(16'h410C, r);
    check("be_color_b0_only", r, 32'h5);
    wr(16'h3104, 32'h1234_5678, 4'hF);
    rd(16'h4104, r);
    check("foreign_base_ignored", r, 32'h00AB_0000);
    wr(16'h3100, 32'h1, 4'hF);
    check("foreign_no_start", FLTRG_START, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flt_regctrl_mc.md
# flt_regctrl_mc

Multi-channel register controller for the filter subsystem. It decodes the 16-bit register bus into a global control and interrupt bank plus NCH per-channel banks. It stages per-channel VRAM source, frame and colour settings and commits them atomically on start. It queues start requests while a channel is busy and merges per-channel interrupts into one level IRQ with write-1-to-clear status.

## Interface
Parameters:
- NCH, 2: number of filter channels, 1..4.
- COLOR_W, 3: colour-mode field width, 1..8.
- RST_CYC, 4: soft-reset pulse length in cycles, 1..15.
- BASE, 4'h4: value of WRADDR/RDADDR[15:12] that selects this block.

Ports:
- CLK  in  1  clock
- ARST  in  1  reset, synchronous, active-high
- WRADDR  in  16  write address
- BYTEEN  in  4  write byte enables
- WREN  in  1  write strobe, one cycle per write
- WDATA  in  32  write data
- RDADDR  in  16  read address
- RDEN  in  1  read strobe; no side effects
- RDATA  out  32  read data, combinational from RDADDR
- FLTVC_INT  in  NCH  per-channel done pulse
- FLTVC_BUSY  in  NCH  per-channel busy level
- FLTRG_IRQ  out  1  interrupt, level
- FLTRG_RSTS  out  1  soft-reset to datapath
- FLTRG_START  out  NCH  per-channel start, one-cycle pulse
- FLTRG_VRAMSRC  out  32*NCH  committed source address; channel c is at [32c+31:32c]
- FLTRG_VRAMFRM  out  32*NCH  committed frame address, same packing
- FLTRG_COLOR  out  COLOR_W*NCH  committed colour mode, same packing

## Operation
- Writes are accepted only when WREN=1 and WRADDR[15:12]=BASE. Decode uses WRADDR[11:2]. Writes to unmapped addresses are ignored.
- Global bank:
  - 0x000 GCTRL: bit1 W1 starts a soft reset. Reads return 0.
  - 0x004 GSTAT: read-only, {pending[NCH], busy[NCH]}. Pending is at bits [8+NCH-1:8]; busy is at bits [NCH-1:0].
  - 0x008 INTEN: bits [NCH-1:0], read/write.
  - 0x00C INTSTAT: bits [NCH-1:0]. Writing 1 clears a bit; writing 0 has no effect.
- Channel c bank, base 0x100 + 0x10*c:
  - +0x0 CCTRL: bit0 W1 requests a start. Reads return {pending at bit 8, busy at bit 0}.
  - +0x4 SRC staging register, byte-enabled.
  - +0x8 FRM staging register, byte-enabled.
  - +0xC COLOR staging register, bits [COLOR_W-1:0], written with BYTEEN[0].
- Staging registers read back their staged value. The output ports carry committed copies only.
- Start request on channel c:
  - Idle (BUSY[c]=0 and pending=0): commit staging to outputs and pulse START[c].
  - Busy: set pending[c].
  - A request while pending[c]=1 is dropped.
  - While pending, later staging writes are still accepted. Commit uses the staging values at launch time.
- Pending launch: at the first edge where pending[c]=1 and BUSY[c]=0, commit, pulse START[c], and clear pending[c].
- Interrupts:
  - INTSTAT[c] is set by FLTVC_INT[c] regardless of INTEN.
  - FLTRG_IRQ is a register loaded with |(INTSTAT & INTEN).
  - If a set and a W1C of the same bit occur on the same edge, the set wins.
- Soft reset:
  - FLTRG_RSTS is asserted for exactly RST_CYC cycles.
  - It clears all pending bits and INTSTAT, and suppresses START for its duration.
  - INTEN, staging and committed registers are retained.
  - Start requests written during RSTS are dropped.
  - A GCTRL bit1 write during RSTS restarts the count.
- Reset values on ARST: all outputs 0, staging 0, INTEN 0, INTSTAT 0, pending 0, soft-reset counter 0.

## Timing
- Write sampled at edge k, channel idle: START[c] is high for the cycle after edge k. The committed outputs change at edge k, in the same cycle.
- Pending launch: BUSY[c] sampled low at edge j gives START[c] high for the cycle after j.
- START is never high for two consecutive cycles on the same channel.
- FLTVC_INT[c] at edge k sets INTSTAT[c] at edge k. FLTRG_IRQ rises at edge k+1 (1-cycle latency). W1C clearing works the same way.
- Soft reset: GCTRL write at edge k gives RSTS high during cycles k+1 .. k+RST_CYC.
- Per-channel start logic and interrupt bits are independent. Simultaneous events on different channels are all honoured in the same cycle.

## Structure
- Package flt_regmc_pkg holds:
  - global offsets: GCTRL, GSTAT, INTEN, INTSTAT;
  - CH_BASE=0x100, CH_STRIDE=0x10, and per-channel offsets;
  - field bit positions;
  - NCH_MAX=4.
- Sub-module flt_regch is instantiated NCH times with a generate loop. Each instance holds staging, committed, pending and start-pulse logic for one channel. The top level holds decode, INTEN/INTSTAT, the IRQ register, the soft-reset counter and the read mux.

## Test plan
- Reset: assert ARST for 2 cycles → all outputs 0 and RDATA=0 at every mapped address.
- Idle start, ch0: write SRC=0x1000_0000, FRM=0x2000_0000, COLOR=5, then CCTRL=1 → START[0] high for exactly 1 cycle; outputs equal the written values in that cycle.
- Busy start, ch1: hold BUSY[1]=1, write SRC=0xA0, CCTRL=1, then SRC=0xB0 and a second CCTRL=1 → GSTAT bit9=1; one START[1] pulse 1 cycle after BUSY drops; VRAMSRC ch1=0xB0.
- IRQ: INTEN=0x1, pulse INT[1] → IRQ stays 0, INTSTAT=0x2. Pulse INT[0] → IRQ=1 one cycle later. W1C 0x1 in the same cycle as a second INT[0] → bit stays set.
- Soft reset: RST_CYC=4, pending on ch0, write GCTRL=0x2 → RSTS high for 4 cycles, pending cleared, no START pulses, INTEN and committed values unchanged.
- Byte enables: BYTEEN=0x4, WDATA=0x00AB0000 to ch0 SRC → staged value 0x00AB0000 from 0; other channels untouched; a write with WRADDR[15:12]=0x3 is ignored.
